// File: rtl/uart_packet_scheduler.sv
// rtl/uart_packet_scheduler.sv - round-robin Y/U/V packet arbiter and UART byte serialiser
// Optional feature macro: UART_SCHED_FRAME_MARKER_EN (end-of-frame marker byte between packets)
module uart_packet_scheduler #(
    parameter int         PacketLength = 6,
    parameter int         IdModulus    = 255,
    parameter logic [7:0] FrameMarker  = 8'hFF
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [2:0]                    i_req,
    input  logic [8*(PacketLength-1)-1:0] i_body_y,
    input  logic [8*(PacketLength-1)-1:0] i_body_u,
    input  logic [8*(PacketLength-1)-1:0] i_body_v,
    input  logic                          i_frame_end,
    input  logic                          i_uart_allowed,
    output logic [2:0]                    o_grant,
    output logic [7:0]                    o_frame,
    output logic                          o_uart_ready,
    output logic                          o_busy
);

    localparam int              BodyW   = 8 * (PacketLength - 1);
    localparam int              CntW    = $clog2(PacketLength + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(PacketLength - 1);
    localparam logic [7:0]      LastId  = 8'(IdModulus - 1);

`ifdef UART_SCHED_FRAME_MARKER_EN
    typedef enum logic [1:0] {IDLE, SEND, MARKER} state_t;
    logic pending;
    logic do_marker;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
    logic unused_marker_cfg;
    assign unused_marker_cfg = i_frame_end | (|FrameMarker);
`endif

    state_t            state;
    state_t            state_next;
    logic [7:0]        id;
    logic [1:0]        ptr;
    logic [1:0]        gidx;
    logic [CntW-1:0]   cnt;
    logic [BodyW-1:0]  body;
    logic [1:0]        cand1;
    logic [1:0]        cand2;
    logic [1:0]        sel_idx;
    logic              sel_valid;
    logic [BodyW-1:0]  sel_body;
    logic              strobe_ok;
    logic              do_grant;
    logic              do_strobe;

    assign o_busy = (state != IDLE);

    // A byte may go out only when the UART allows it, never right after a strobe,
    // and not in the grant cycle while the body register is being loaded.
    assign strobe_ok = i_uart_allowed && !o_uart_ready && (o_grant == 3'b000);

    // Round-robin pick: first requester at or above the pointer, wrapping Y->U->V->Y
    always_comb begin
        cand1     = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        cand2     = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
        sel_valid = 1'b1;
        sel_idx   = ptr;
        if (i_req[ptr])        sel_idx = ptr;
        else if (i_req[cand1]) sel_idx = cand1;
        else if (i_req[cand2]) sel_idx = cand2;
        else                   sel_valid = 1'b0;
        case (sel_idx)
            2'd0:    sel_body = i_body_y;
            2'd1:    sel_body = i_body_u;
            default: sel_body = i_body_v;
        endcase
    end

    // Next-state and per-cycle action decode
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_strobe  = 1'b0;
`ifdef UART_SCHED_FRAME_MARKER_EN
        do_marker  = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef UART_SCHED_FRAME_MARKER_EN
                if (pending) state_next = MARKER;
                else
`endif
                if (sel_valid) begin
                    do_grant   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (strobe_ok) begin
                    do_strobe = 1'b1;
                    if (cnt == LastCnt) state_next = IDLE;
                end
            end
`ifdef UART_SCHED_FRAME_MARKER_EN
            MARKER: begin
                if (strobe_ok) begin
                    do_marker  = 1'b1;
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_next;
    end

    // Packet datapath: latch body on grant, shift bytes out, roll ID and pointer at packet end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            id           <= 8'h00;
            ptr          <= 2'd0;
            gidx         <= 2'd0;
            cnt          <= '0;
            body         <= '0;
            o_grant      <= 3'b000;
            o_frame      <= 8'h00;
            o_uart_ready <= 1'b0;
`ifdef UART_SCHED_FRAME_MARKER_EN
            pending      <= 1'b0;
`endif
        end else begin
            o_grant      <= 3'b000;
            o_uart_ready <= 1'b0;
            if (do_grant) begin
                body    <= sel_body;
                gidx    <= sel_idx;
                o_grant <= 3'b001 << sel_idx;
                cnt     <= '0;
            end
            if (do_strobe) begin
                o_uart_ready <= 1'b1;
                cnt          <= cnt + CntW'(1);
                if (cnt == '0) begin
                    o_frame <= id;
                end else begin
                    o_frame <= body[BodyW-1 -: 8];
                    body    <= {body[BodyW-9:0], 8'h00};
                end
                if (cnt == LastCnt) begin
                    id  <= (id == LastId) ? 8'h00 : id + 8'd1;
                    ptr <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
                end
            end
`ifdef UART_SCHED_FRAME_MARKER_EN
            if (do_marker) begin
                o_frame      <= FrameMarker;
                o_uart_ready <= 1'b1;
                pending      <= 1'b0;
            end
            if (i_frame_end) pending <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_uart_packet_scheduler.sv
// tb/tb_uart_packet_scheduler.sv - directed self-checking bench for uart_packet_scheduler
module tb_uart_packet_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  i_req;
    logic [39:0] i_body_y, i_body_u, i_body_v;
    logic        i_frame_end;
    logic        i_uart_allowed;
    logic [2:0]  o_grant;
    logic [7:0]  o_frame;
    logic        o_uart_ready;
    logic        o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] byte_q[$];
    logic [2:0] grant_q[$];
    int         adj_viol = 0;
    logic       prev_ready = 1'b0;

    uart_packet_scheduler dut (
        .CLK(CLK), .RST(RST), .i_req(i_req),
        .i_body_y(i_body_y), .i_body_u(i_body_u), .i_body_v(i_body_v),
        .i_frame_end(i_frame_end), .i_uart_allowed(i_uart_allowed),
        .o_grant(o_grant), .o_frame(o_frame), .o_uart_ready(o_uart_ready), .o_busy(o_busy)
    );

    always #5 CLK = ~CLK;

    // Log grants and strobed bytes; flag back-to-back strobes
    always @(negedge CLK) begin
        if (o_grant != 3'b000) grant_q.push_back(o_grant);
        if (o_uart_ready === 1'b1) byte_q.push_back(o_frame);
        if (o_uart_ready === 1'b1 && prev_ready === 1'b1) adj_viol++;
        prev_ready = o_uart_ready;
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && byte_q.size() < n; i++) tick();
    endtask

    task automatic wait_grants(input int n, input int budget);
        for (int i = 0; i < budget && grant_q.size() < n; i++) tick();
    endtask

    task automatic do_reset();
        RST = 1'b0; i_req = 3'b000; i_frame_end = 1'b0; i_uart_allowed = 1'b1;
        tick(); tick();
        RST = 1'b1;
        byte_q.delete(); grant_q.delete();
        tick();
    endtask

    task automatic test_reset();
        i_body_y = '0; i_body_u = '0; i_body_v = '0;
        do_reset();
        n_cmp++; if (o_grant !== 3'b000) begin n_bad++; $display("FAIL reset_grant: got %b expected 000", o_grant); end
        n_cmp++; if (o_frame !== 8'h00) begin n_bad++; $display("FAIL reset_frame: got %h expected 00", o_frame); end
        n_cmp++; if (o_uart_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", o_uart_ready); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    endtask

    task automatic test_single();
        logic [7:0] exp[$];
        logic [7:0] got;
        do_reset();
        i_body_y = 40'h0102030405;
        i_req = 3'b001;
        tick();
        n_cmp++; if (o_grant !== 3'b001) begin n_bad++; $display("FAIL single_grant: got %b expected 001", o_grant); end
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", o_busy); end
        i_req = 3'b000;
        tick();
        n_cmp++; if (o_grant !== 3'b000) begin n_bad++; $display("FAIL single_grant_pulse: got %b expected 000", o_grant); end
        n_cmp++; if (o_uart_ready !== 1'b0) begin n_bad++; $display("FAIL single_first_latency: got %b expected 0", o_uart_ready); end
        wait_bytes(6, 100);
        exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        for (int k = 0; k < 6; k++) begin
            got = (k < byte_q.size()) ? byte_q[k] : 8'hxx;
            n_cmp++; if (got !== exp[k]) begin n_bad++; $display("FAIL single_byte%0d: got %h expected %h", k, got, exp[k]); end
        end
        tick(); tick();
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %b expected 0", o_busy); end
        i_body_v = 40'h5152535455;
        i_req = 3'b100;
        wait_grants(2, 50);
        i_req = 3'b000;
        wait_bytes(12, 100);
        got = (grant_q.size() > 1) ? {5'b0, grant_q[1]} : 8'hxx;
        n_cmp++; if (got !== 8'h04) begin n_bad++; $display("FAIL single_second_grant: got %h expected 04", got); end
        got = (byte_q.size() > 6) ? byte_q[6] : 8'hxx;
        n_cmp++; if (got !== 8'h01) begin n_bad++; $display("FAIL single_next_id: got %h expected 01", got); end
        got = (byte_q.size() > 7) ? byte_q[7] : 8'hxx;
        n_cmp++; if (got !== 8'h51) begin n_bad++; $display("FAIL single_v_byte1: got %h expected 51", got); end
    endtask

    task automatic test_round_robin();
        logic [39:0] bodies[3];
        logic [2:0]  exp_g[4];
        int          order[4];
        logic [7:0]  got;
        logic [39:0] b;
        do_reset();
        bodies[0] = 40'h1011121314; bodies[1] = 40'h2021222324; bodies[2] = 40'h3031323334;
        i_body_y = bodies[0]; i_body_u = bodies[1]; i_body_v = bodies[2];
        order = '{0, 1, 2, 0};
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        i_req = 3'b111;
        wait_grants(4, 200);
        i_req = 3'b000;
        wait_bytes(24, 200);
        for (int p = 0; p < 4; p++) begin
            got = (p < grant_q.size()) ? {5'b0, grant_q[p]} : 8'hxx;
            n_cmp++; if (got !== {5'b0, exp_g[p]}) begin n_bad++; $display("FAIL rr_grant%0d: got %h expected %h", p, got, exp_g[p]); end
            b = bodies[order[p]];
            for (int k = 0; k < 6; k++) begin
                got = (6*p+k < byte_q.size()) ? byte_q[6*p+k] : 8'hxx;
                if (k == 0) begin
                    n_cmp++; if (got !== 8'(p)) begin n_bad++; $display("FAIL rr_id%0d: got %h expected %h", p, got, 8'(p)); end
                end else begin
                    n_cmp++; if (got !== b[8*(5-k) +: 8]) begin n_bad++; $display("FAIL rr_pkt%0d_byte%0d: got %h expected %h", p, k, got, b[8*(5-k) +: 8]); end
                end
            end
        end
    endtask

    task automatic test_frame_end();
        logic [7:0] exp[$];
        logic [7:0] got;
        do_reset();
        i_body_y = 40'h6162636465; i_body_u = 40'h7172737475;
        i_req = 3'b001;
        wait_grants(1, 20);
        i_req = 3'b010;
        wait_bytes(1, 20);
        i_frame_end = 1'b1; tick(); i_frame_end = 1'b0;
        wait_bytes(3, 20);
        i_frame_end = 1'b1; tick(); i_frame_end = 1'b0;
        wait_grants(2, 100);
        i_req = 3'b000;
        exp = '{8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
`ifdef UART_SCHED_FRAME_MARKER_EN
        exp.push_back(8'hFF);
`endif
        exp.push_back(8'h01);
        for (int k = 0; k < 5; k++) exp.push_back(8'h71 + 8'(k));
        wait_bytes(exp.size(), 200);
        repeat (20) tick();
        n_cmp++; if (byte_q.size() !== exp.size()) begin n_bad++; $display("FAIL fe_count: got %0d expected %0d", byte_q.size(), exp.size()); end
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < byte_q.size()) ? byte_q[k] : 8'hxx;
            n_cmp++; if (got !== exp[k]) begin n_bad++; $display("FAIL fe_byte%0d: got %h expected %h", k, got, exp[k]); end
        end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL fe_idle: got %b expected 0", o_busy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] got;
        do_reset();
        i_body_y = 40'hA1A2A3A4A5;
        i_req = 3'b001;
        wait_grants(1, 20);
        i_req = 3'b000;
        i_body_y = 40'h0;
        wait_bytes(3, 50);
        i_uart_allowed = 1'b0;
        repeat (20) tick();
        n_cmp++; if (byte_q.size() !== 3) begin n_bad++; $display("FAIL bp_stall_count: got %0d expected 3", byte_q.size()); end
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL bp_stall_busy: got %b expected 1", o_busy); end
        i_uart_allowed = 1'b1;
        wait_bytes(6, 50);
        for (int k = 3; k < 6; k++) begin
            got = (k < byte_q.size()) ? byte_q[k] : 8'hxx;
            n_cmp++; if (got !== 8'hA0 + 8'(k)) begin n_bad++; $display("FAIL bp_byte%0d: got %h expected %h", k, got, 8'hA0 + 8'(k)); end
        end
    endtask

    task automatic test_id_wrap();
        logic [7:0] got;
        int         idx[4];
        logic [7:0] exp[4];
        do_reset();
        i_body_y = 40'hC1C2C3C4C5;
        i_req = 3'b001;
        wait_bytes(6*257, 5000);
        i_req = 3'b000;
        repeat (20) tick();
        n_cmp++; if (byte_q.size() !== 6*257) begin n_bad++; $display("FAIL wrap_count: got %0d expected %0d", byte_q.size(), 6*257); end
        idx = '{253, 254, 255, 256};
        exp = '{8'd253, 8'd254, 8'd0, 8'd1};
        for (int p = 0; p < 4; p++) begin
            got = (6*idx[p] < byte_q.size()) ? byte_q[6*idx[p]] : 8'hxx;
            n_cmp++; if (got !== exp[p]) begin n_bad++; $display("FAIL wrap_id_pkt%0d: got %0d expected %0d", idx[p], got, exp[p]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        do_reset();
        i_body_y = 40'hB1B2B3B4B5;
        i_req = 3'b001;
        wait_grants(1, 20);
        i_req = 3'b000;
        wait_bytes(4, 50);
        RST = 1'b0;
        tick();
        n_cmp++; if (o_grant !== 3'b000) begin n_bad++; $display("FAIL rm_grant: got %b expected 000", o_grant); end
        n_cmp++; if (o_frame !== 8'h00) begin n_bad++; $display("FAIL rm_frame: got %h expected 00", o_frame); end
        n_cmp++; if (o_uart_ready !== 1'b0) begin n_bad++; $display("FAIL rm_ready: got %b expected 0", o_uart_ready); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b expected 0", o_busy); end
        RST = 1'b1;
        repeat (10) tick();
        n_cmp++; if (byte_q.size() !== 4) begin n_bad++; $display("FAIL rm_no_strobes: got %0d expected 4", byte_q.size()); end
        byte_q.delete(); grant_q.delete();
        i_req = 3'b011;
        wait_grants(1, 20);
        i_req = 3'b000;
        wait_bytes(6, 50);
        got = (grant_q.size() > 0) ? {5'b0, grant_q[0]} : 8'hxx;
        n_cmp++; if (got !== 8'h01) begin n_bad++; $display("FAIL rm_next_grant: got %h expected 01", got); end
        got = (byte_q.size() > 0) ? byte_q[0] : 8'hxx;
        n_cmp++; if (got !== 8'h00) begin n_bad++; $display("FAIL rm_next_id: got %h expected 00", got); end
        got = (byte_q.size() > 1) ? byte_q[1] : 8'hxx;
        n_cmp++; if (got !== 8'hB1) begin n_bad++; $display("FAIL rm_next_byte1: got %h expected b1", got); end
    endtask

    initial begin
        RST = 1'b0; i_req = 3'b000; i_frame_end = 1'b0; i_uart_allowed = 1'b1;
        i_body_y = '0; i_body_u = '0; i_body_v = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_frame_end();
        test_backpressure();
        test_id_wrap();
        test_reset_mid();
        n_cmp++; if (adj_viol !== 0) begin n_bad++; $display("FAIL strobe_spacing: got %0d adjacent strobes expected 0", adj_viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
